// File: rtl/otter_fetch_pkg.sv
// otter_fetch_pkg: shared entry type and sizing for the fetch queue.
package otter_fetch_pkg;
    localparam int FQ_XLEN  = 32;
    localparam int FQ_DEPTH = 8;
    localparam int FQ_PTR_W = $clog2(FQ_DEPTH);
    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] ir;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: entry storage with a paired write port and two async read ports.
module fetch_queue_mem
    import otter_fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic         i_clk,
    input  logic         i_we,
    input  logic [PW-1:0] i_waddr,
    input  fetch_entry_t i_wdata_0,
    input  fetch_entry_t i_wdata_1,
    input  logic [PW-1:0] i_raddr_0,
    input  logic [PW-1:0] i_raddr_1,
    output fetch_entry_t o_rdata_0,
    output fetch_entry_t o_rdata_1
);
    fetch_entry_t r_mem [DEPTH];
    logic [PW-1:0] w_waddr_1;
    // Second slot wraps naturally with the pointer width, so a pair may straddle DEPTH-1/0.
    assign w_waddr_1 = i_waddr + PW'(1);
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr]   <= i_wdata_0;
            r_mem[w_waddr_1] <= i_wdata_1;
        end
    end
    assign o_rdata_0 = r_mem[i_raddr_0];
    assign o_rdata_1 = r_mem[i_raddr_1];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: 2-wide in-order instruction buffer between fetch and decode,
// cleared on redirect.
module fetch_queue
    import otter_fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int XLEN  = FQ_XLEN,
    localparam int PW = $clog2(DEPTH),
    localparam int OW = PW + 1
) (
    input  logic            CLK,
    input  logic            EXT_RESET,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc_0,
    input  logic [XLEN-1:0] in_pc_1,
    input  logic [XLEN-1:0] in_ir_0,
    input  logic [XLEN-1:0] in_ir_1,
    output logic            in_ready,
    output logic            out_valid_0,
    output logic            out_valid_1,
    output logic [XLEN-1:0] out_pc_0,
    output logic [XLEN-1:0] out_ir_0,
    output logic [XLEN-1:0] out_pc_1,
    output logic [XLEN-1:0] out_ir_1,
    input  logic [1:0]      deq_count,
    output logic [OW-1:0]   occupancy
);
    logic [PW-1:0] r_head, r_tail;
    logic [OW-1:0] r_occ;
    logic [OW-1:0] w_req, w_eff;
    logic          w_enq;
    fetch_entry_t  w_wr_0, w_wr_1, w_rd_0, w_rd_1;

    assign w_req    = (deq_count == 2'd3) ? OW'(2) : OW'(deq_count);
    assign w_eff    = (w_req > r_occ) ? r_occ : w_req;
    // Ready looks only at registered occupancy so there is no deq->ready path.
    assign in_ready = (OW'(DEPTH) - r_occ) >= OW'(2);
    assign w_enq    = in_valid && in_ready && !flush;
    assign w_wr_0   = '{pc: in_pc_0, ir: in_ir_0};
    assign w_wr_1   = '{pc: in_pc_1, ir: in_ir_1};

    always_ff @(posedge CLK or posedge EXT_RESET) begin
        if (EXT_RESET) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            r_head <= r_head + PW'(w_eff);
            r_tail <= r_tail + (w_enq ? PW'(2) : PW'(0));
            r_occ  <= r_occ + (w_enq ? OW'(2) : OW'(0)) - w_eff;
        end
    end

    fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .i_clk    (CLK),
        .i_we     (w_enq),
        .i_waddr  (r_tail),
        .i_wdata_0(w_wr_0),
        .i_wdata_1(w_wr_1),
        .i_raddr_0(r_head),
        .i_raddr_1(r_head + PW'(1)),
        .o_rdata_0(w_rd_0),
        .o_rdata_1(w_rd_1)
    );

    assign occupancy   = r_occ;
    assign out_valid_0 = r_occ != '0;
    assign out_valid_1 = r_occ >= OW'(2);
    assign out_pc_0    = w_rd_0.pc;
    assign out_ir_0    = w_rd_0.ir;
    assign out_pc_1    = w_rd_1.pc;
    assign out_ir_1    = w_rd_1.ir;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenario checks for fetch_queue.
module tb_fetch_queue;
    logic        CLK = 0, EXT_RESET = 0, flush = 0, in_valid = 0;
    logic [31:0] in_pc_0 = 0, in_pc_1 = 0, in_ir_0 = 0, in_ir_1 = 0;
    logic [1:0]  deq_count = 0;
    logic        in_ready, out_valid_0, out_valid_1;
    logic [31:0] out_pc_0, out_ir_0, out_pc_1, out_ir_1;
    logic [3:0]  occupancy;
    int total = 0, bad = 0;
    logic [31:0] exp_head, next_pc;

    fetch_queue dut (
        .CLK(CLK), .EXT_RESET(EXT_RESET), .flush(flush), .in_valid(in_valid),
        .in_pc_0(in_pc_0), .in_pc_1(in_pc_1), .in_ir_0(in_ir_0), .in_ir_1(in_ir_1),
        .in_ready(in_ready), .out_valid_0(out_valid_0), .out_valid_1(out_valid_1),
        .out_pc_0(out_pc_0), .out_ir_0(out_ir_0), .out_pc_1(out_pc_1), .out_ir_1(out_ir_1),
        .deq_count(deq_count), .occupancy(occupancy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0013;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] d, input logic f);
        in_valid = v; in_pc_0 = pc; in_pc_1 = pc + 4;
        in_ir_0 = ir_of(pc); in_ir_1 = ir_of(pc + 4);
        deq_count = d; flush = f;
    endtask

    task automatic tick;
        @(posedge CLK); #1;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_reset;
        EXT_RESET = 1; #3;
        total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        total++; if ({out_valid_0, out_valid_1} !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b want=00", {out_valid_0, out_valid_1}); end
        @(posedge CLK); #2; EXT_RESET = 0; #1;
    endtask

    task automatic test_first_pair;
        drive(1, 32'h0, 0, 0); tick;
        total++; if ({out_valid_0, out_valid_1} !== 2'b11) begin bad++; $display("FAIL first_valid got=%b want=11", {out_valid_0, out_valid_1}); end
        total++; if (out_pc_0 !== 32'h0 || out_pc_1 !== 32'h4) begin bad++; $display("FAIL first_pc got=%h,%h want=0,4", out_pc_0, out_pc_1); end
        total++; if (out_ir_0 !== ir_of(0) || out_ir_1 !== ir_of(4)) begin bad++; $display("FAIL first_ir got=%h,%h want=%h,%h", out_ir_0, out_ir_1, ir_of(0), ir_of(4)); end
        total++; if (occupancy !== 4'd2) begin bad++; $display("FAIL first_occ got=%0d want=2", occupancy); end
        next_pc = 32'h8; exp_head = 32'h0;
    endtask

    task automatic test_full_drop;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL occ6_ready got=%b want=1", in_ready); end
            end
            drive(1, next_pc, 0, 0); tick; next_pc += 8;
        end
        total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL full_occ got=%0d want=8", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", in_ready); end
        drive(1, 32'h20, 0, 0); tick;
        total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL drop_occ got=%0d want=8", occupancy); end
        total++; if (out_pc_0 !== 32'h0) begin bad++; $display("FAIL drop_head got=%h want=0", out_pc_0); end
    endtask

    task automatic test_steady;
        drive(0, 0, 2, 0); tick; exp_head += 8;
        total++; if (occupancy !== 4'd6) begin bad++; $display("FAIL drain_occ got=%0d want=6", occupancy); end
        for (int i = 0; i < 20; i++) begin
            total++; if (out_pc_0 !== exp_head || out_pc_1 !== exp_head + 4) begin bad++; $display("FAIL steady_pc[%0d] got=%h,%h want=%h,%h", i, out_pc_0, out_pc_1, exp_head, exp_head + 4); end
            drive(1, next_pc, 2, 0); tick; next_pc += 8; exp_head += 8;
            total++; if (occupancy !== 4'd6) begin bad++; $display("FAIL steady_occ[%0d] got=%0d want=6", i, occupancy); end
        end
    endtask

    task automatic test_straddle;
        drive(0, 0, 1, 0); tick; exp_head += 4;
        drive(0, 0, 2, 0); tick; exp_head += 8;
        total++; if (occupancy !== 4'd3) begin bad++; $display("FAIL s_occ3 got=%0d want=3", occupancy); end
        drive(1, next_pc, 1, 0); tick; next_pc += 8; exp_head += 4;
        total++; if (occupancy !== 4'd4) begin bad++; $display("FAIL s_occ4 got=%0d want=4", occupancy); end
        drive(0, 0, 1, 0); tick; exp_head += 4;
        total++; if (out_pc_0 !== exp_head || out_pc_1 !== exp_head + 4) begin bad++; $display("FAIL wrap_pc got=%h,%h want=%h,%h", out_pc_0, out_pc_1, exp_head, exp_head + 4); end
        total++; if (out_ir_1 !== ir_of(exp_head + 4)) begin bad++; $display("FAIL wrap_ir got=%h want=%h", out_ir_1, ir_of(exp_head + 4)); end
        for (int i = 0; i < 2; i++) begin drive(1, next_pc, 0, 0); tick; next_pc += 8; end
        total++; if (occupancy !== 4'd7 || in_ready !== 1'b0) begin bad++; $display("FAIL occ7 got=%0d/%b want=7/0", occupancy, in_ready); end
    endtask

    task automatic test_underflow;
        drive(0, 0, 3, 0); tick; exp_head += 8;
        total++; if (occupancy !== 4'd5 || out_pc_0 !== exp_head) begin bad++; $display("FAIL deq3 got=%0d/%h want=5/%h", occupancy, out_pc_0, exp_head); end
        drive(0, 0, 2, 0); tick; drive(0, 0, 2, 0); tick;
        total++; if (occupancy !== 4'd1 || out_valid_1 !== 1'b0) begin bad++; $display("FAIL occ1 got=%0d/%b want=1/0", occupancy, out_valid_1); end
        drive(0, 0, 2, 0); tick;
        total++; if (occupancy !== 4'd0 || out_valid_0 !== 1'b0) begin bad++; $display("FAIL underflow got=%0d/%b want=0/0", occupancy, out_valid_0); end
        drive(0, 0, 2, 0); tick;
        total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL empty_deq got=%0d want=0", occupancy); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) begin drive(1, next_pc, 0, 0); tick; next_pc += 8; end
        total++; if (occupancy !== 4'd6) begin bad++; $display("FAIL pre_flush got=%0d want=6", occupancy); end
        drive(1, 32'h1000, 2, 1); tick;
        total++; if (occupancy !== 4'd0 || in_ready !== 1'b1 || {out_valid_0, out_valid_1} !== 2'b00) begin bad++; $display("FAIL flush got=%0d/%b/%b want=0/1/00", occupancy, in_ready, {out_valid_0, out_valid_1}); end
        drive(1, 32'h2000, 0, 0); tick;
        total++; if (out_pc_0 !== 32'h2000 || out_pc_1 !== 32'h2004 || occupancy !== 4'd2) begin bad++; $display("FAIL post_flush got=%h,%h/%0d want=2000,2004/2", out_pc_0, out_pc_1, occupancy); end
    endtask

    task automatic test_async_reset;
        @(posedge CLK); #2; EXT_RESET = 1; #1;
        total++; if (occupancy !== 4'd0 || {out_valid_0, out_valid_1} !== 2'b00 || in_ready !== 1'b1) begin bad++; $display("FAIL async_rst got=%0d/%b/%b want=0/00/1", occupancy, {out_valid_0, out_valid_1}, in_ready); end
        #1; EXT_RESET = 0;
        drive(1, 32'h40, 0, 0); tick;
        total++; if (out_pc_0 !== 32'h40 || occupancy !== 4'd2) begin bad++; $display("FAIL after_rst got=%h/%0d want=40/2", out_pc_0, occupancy); end
    endtask

    initial begin
        test_reset;
        test_first_pair;
        test_full_drop;
        test_steady;
        test_straddle;
        test_underflow;
        test_flush;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
